// File: rtl/servo_pkg.sv
// Shared types, width helpers and default sizing for the multi-channel servo PWM generator.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    localparam int DEF_CLK_HZ   = 50_000_000;
    localparam int DEF_ANGLE_W  = 8;
    localparam int DEF_FRAME_US = 20_000;

    function automatic int us_to_ticks(input int us, input int clk_hz);
        return us * (clk_hz / 1_000_000);
    endfunction

    localparam int TICK_W = $clog2(us_to_ticks(DEF_FRAME_US, DEF_CLK_HZ));
    localparam int DIV_W  = DEF_ANGLE_W + TICK_W;

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Angle write port of servo_pwm_multi: valid/ready handshake carrying channel and angle.
interface servo_pwm_multi_if #(
    parameter int CH_W    = 2,
    parameter int ANGLE_W = 8
);
    logic               wr_valid;
    logic               wr_ready;
    logic [CH_W-1:0]    wr_ch;
    logic [ANGLE_W-1:0] wr_angle;

    modport master (output wr_valid, output wr_ch, output wr_angle, input wr_ready);
    modport slave  (input wr_valid, input wr_ch, input wr_angle, output wr_ready);
endinterface

// File: rtl/servo_angle_div.sv
// Sequential restoring divider, one quotient bit per cycle, shared by all servo channels.
module servo_angle_div #(
    parameter int ANGLE_W = servo_pkg::DEF_ANGLE_W,
    parameter int TICK_W  = servo_pkg::TICK_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [ANGLE_W+TICK_W-1:0]  dividend_i,
    input  logic [ANGLE_W-1:0]         divisor_i,
    output logic                       done_o,
    output logic [TICK_W-1:0]          quotient_o
);
    localparam int DIV_W = ANGLE_W + TICK_W;
    localparam int CNT_W = $clog2(DIV_W + 1);

    // work_q shifts dividend bits out of the top while quotient bits enter at the bottom
    logic [DIV_W-1:0]   work_q, work_d;
    logic [ANGLE_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ANGLE_W:0]   trial;
    logic [ANGLE_W:0]   diff;

    always_comb begin
        work_d = work_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        trial  = {rem_q, work_q[DIV_W-1]};
        diff   = trial - {1'b0, divisor_i};
        if (start_i) begin
            work_d = dividend_i;
            rem_d  = '0;
            cnt_d  = CNT_W'(DIV_W);
        end else if (cnt_q != '0) begin
            if (trial >= {1'b0, divisor_i}) begin
                rem_d  = diff[ANGLE_W-1:0];
                work_d = {work_q[DIV_W-2:0], 1'b1};
            end else begin
                rem_d  = trial[ANGLE_W-1:0];
                work_d = {work_q[DIV_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else begin
            work_q <= work_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
        end
    end

    // Asserted while the final iteration runs, so the quotient is valid on the next cycle.
    assign done_o     = (cnt_q == CNT_W'(1));
    assign quotient_o = (|work_q[DIV_W-1:TICK_W]) ? '1 : work_q[TICK_W-1:0];

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: angle writes are converted to pulse widths and applied at frame boundaries.
// Optional per-frame slew limiting is built when SERVO_SLEW_EN is defined.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int N_CH       = 4,
    parameter int ANGLE_W    = 8,
    parameter int ANGLE_MAX  = 180,
    parameter int FRAME_US   = 20_000,
    parameter int MIN_US     = 1000,
    parameter int MAX_US     = 2000,
    parameter int SLEW_TICKS = 5000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    servo_pwm_multi_if.slave      wr,
    output logic [N_CH-1:0]       pwm_out,
    output logic                  frame_start
);
    localparam int FRAME_TICKS  = us_to_ticks(FRAME_US, CLK_HZ);
    localparam int MIN_TICKS    = us_to_ticks(MIN_US, CLK_HZ);
    localparam int MAX_TICKS    = us_to_ticks(MAX_US, CLK_HZ);
    localparam int SPAN         = MAX_TICKS - MIN_TICKS;
    localparam int CENTRE_TICKS = (MIN_TICKS + MAX_TICKS) / 2;
    localparam int CNT_W        = $clog2(FRAME_TICKS);
    localparam int QW           = ANGLE_W + CNT_W;
    localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1;

    conv_state_e        state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               frame_start_q;
    logic               boundary;
    logic               div_start;
    logic               div_done;
    logic [CNT_W-1:0]   div_quot;
    logic [CNT_W-1:0]   pend_new;
    logic [ANGLE_W-1:0] angle_clamped;
    logic [QW-1:0]      dividend;

    assign boundary      = (cnt_q == CNT_W'(FRAME_TICKS - 1));
    assign angle_clamped = (wr.wr_angle > ANGLE_W'(ANGLE_MAX)) ? ANGLE_W'(ANGLE_MAX) : wr.wr_angle;
    assign dividend      = QW'(angle_clamped) * QW'(SPAN);
    assign pend_new      = CNT_W'(MIN_TICKS) + div_quot;
    assign frame_start   = frame_start_q;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        wr.wr_ready = 1'b0;
        div_start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                wr.wr_ready = 1'b1;
                if (wr.wr_valid) begin
                    div_start = 1'b1;
                    ch_d      = wr.wr_ch;
                    state_d   = CONV;
                end
            end
            CONV: if (div_done) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            cnt_q         <= boundary ? '0 : cnt_q + 1'b1;
            frame_start_q <= boundary;
        end
    end

    servo_angle_div #(
        .ANGLE_W (ANGLE_W),
        .TICK_W  (CNT_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (dividend),
        .divisor_i  (ANGLE_W'(ANGLE_MAX)),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

`ifdef SERVO_SLEW_EN
    localparam logic [CNT_W-1:0] SLEW = CNT_W'(SLEW_TICKS);
`endif

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] pending_q;
        logic [CNT_W-1:0] active_q;
        logic [CNT_W-1:0] step_d;
        logic             pwm_q;

`ifdef SERVO_SLEW_EN
        always_comb begin
            step_d = pending_q;
            if (pending_q > active_q) begin
                if (pending_q - active_q > SLEW) step_d = active_q + SLEW;
            end else if (active_q - pending_q > SLEW) begin
                step_d = active_q - SLEW;
            end
        end
`else
        assign step_d = pending_q;
`endif

        // Channel indices >= N_CH never match here, so such writes are silently dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pending_q <= CNT_W'(CENTRE_TICKS);
                active_q  <= CNT_W'(CENTRE_TICKS);
                pwm_q     <= 1'b0;
            end else begin
                if (state_q == DONE && ch_q == CH_W'(gi)) pending_q <= pend_new;
                if (boundary) active_q <= step_d;
                pwm_q <= en && (cnt_q < active_q);
            end
        end

        assign pwm_out[gi] = pwm_q;
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi at a reduced clock: 1 tick/us, 400-tick frame, 100..200-tick pulses.
module tb_servo_pwm_multi;
    localparam int N_CH       = 5;
    localparam int ANGLE_W    = 8;
    localparam int FRAME      = 400;
    localparam int LOW_CYCLES = 18;   // DIV_W (8 + 9) iterations plus the DONE cycle
    localparam int SLEW_TICKS = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b1;
    logic [N_CH-1:0] pwm_out;
    logic            frame_start;

    int n_checks = 0;
    int n_errors = 0;
    int exp_w  [N_CH];
    int meas_w [N_CH];

    servo_pwm_multi_if #(.CH_W(3), .ANGLE_W(ANGLE_W)) wr_if ();

    servo_pwm_multi #(
        .CLK_HZ     (1_000_000),
        .N_CH       (N_CH),
        .ANGLE_W    (ANGLE_W),
        .ANGLE_MAX  (180),
        .FRAME_US   (FRAME),
        .MIN_US     (100),
        .MAX_US     (200),
        .SLEW_TICKS (SLEW_TICKS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr          (wr_if),
        .pwm_out     (pwm_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!wr_if.wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_write(input int ch, input int ang);
        int n;
        wait_ready(n);
        if (n >= 200) check_eq("ready_timeout", wr_if.wr_ready, 1);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = 3'(ch);
        wr_if.wr_angle = 8'(ang);
        $display("write ch=%0d angle=%0d at %0t", ch, ang, $time);
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic write_and_check(input int ch, input int ang);
        int n;
        send_write(ch, ang);
        wait_ready(n);
        check_eq($sformatf("wr_latency_ch%0d", ch), n, LOW_CYCLES);
    endtask

    task automatic measure_frame();
        int n;
        int fs_at;
        logic [N_CH-1:0] first;
        n = 0;
        while (!frame_start && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check_eq("fs_seen", frame_start, 1);
        check_eq("pwm_before_rise", pwm_out, 0);
        for (int c = 0; c < N_CH; c++) meas_w[c] = 0;
        fs_at = 0;
        first = '0;
        for (int t = 1; t <= FRAME; t++) begin
            @(negedge clk);
            if (t == 1) first = pwm_out;
            for (int c = 0; c < N_CH; c++) if (pwm_out[c]) meas_w[c]++;
            if (frame_start && fs_at == 0) fs_at = t;
        end
        check_eq("pwm_rise", first, 31);
        check_eq("period", fs_at, FRAME);
    endtask

    task automatic check_widths(input string tag);
        for (int c = 0; c < N_CH; c++)
            check_eq($sformatf("%s_ch%0d", tag, c), meas_w[c], exp_w[c]);
    endtask

    initial begin
        int n;
        int q_ch  [4] = '{0, 5, 2, 0};
        int q_ang [4] = '{90, 0, 0, 45};
        int a_ang [4] = '{0, 180, 255, 7};
        int a_exp [4] = '{100, 200, 200, 103};
`ifdef SERVO_SLEW_EN
        int s_exp [5] = '{160, 170, 180, 190, 200};
`else
        int s_exp [5] = '{200, 200, 200, 200, 200};
`endif
        wr_if.wr_valid = 1'b0;
        wr_if.wr_ch    = '0;
        wr_if.wr_angle = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_pwm", pwm_out, 0);
        check_eq("rst_fs", frame_start, 0);
        check_eq("rst_ready", wr_if.wr_ready, 1);
        rst_n = 1'b1;

        for (int c = 0; c < N_CH; c++) exp_w[c] = 150;
        measure_frame();
        check_widths("centre");

        // ch2 150 -> 200 over consecutive frames
        write_and_check(2, 180);
        for (int f = 0; f < 5; f++) begin
            measure_frame();
            exp_w[2] = s_exp[f];
            check_widths($sformatf("slew_f%0d", f));
        end

`ifndef SERVO_SLEW_EN
        // write lands mid-frame: this frame keeps the old width
        fork
            measure_frame();
            begin
                repeat (5) @(negedge clk);
                write_and_check(1, 45);
            end
        join
        check_widths("midframe_old");
        exp_w[1] = 125;
        measure_frame();
        check_widths("midframe_new");

        for (int i = 0; i < 4; i++) begin
            write_and_check(0, a_ang[i]);
            measure_frame();
            exp_w[0] = a_exp[i];
            check_widths($sformatf("ch0_ang%0d", a_ang[i]));
        end

        // DONE cycle coincides with counter == FRAME-1
        repeat (FRAME - LOW_CYCLES - 1) @(negedge clk);
        send_write(3, 0);
        measure_frame();
        check_widths("coincide_old");
        exp_w[3] = 100;
        measure_frame();
        check_widths("coincide_new");

        wr_if.wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_if.wr_ch    = 3'(q_ch[i]);
            wr_if.wr_angle = 8'(q_ang[i]);
            wait_ready(n);
            if (i > 0) check_eq($sformatf("queue_gap%0d", i), n, LOW_CYCLES);
            $display("write ch=%0d angle=%0d at %0t", q_ch[i], q_ang[i], $time);
            @(negedge clk);
        end
        wr_if.wr_valid = 1'b0;
        wait_ready(n);
        check_eq("queue_gap4", n, LOW_CYCLES);
        exp_w[0] = 125;
        exp_w[2] = 100;
        measure_frame();
        check_widths("queue");
`endif

        repeat (10) @(negedge clk);
        check_eq("en_high_pwm", pwm_out, 31);
        en = 1'b0;
        @(negedge clk);
        check_eq("en_low_pwm", pwm_out, 0);
        en = 1'b1;
        @(negedge clk);
        check_eq("en_back_pwm", pwm_out, 31);
        measure_frame();
        check_widths("after_en");

        repeat (10) @(negedge clk);
        send_write(4, 0);
        repeat (3) @(negedge clk);
        check_eq("conv_busy", wr_if.wr_ready, 0);
        check_eq("pre_rst_pwm", pwm_out, 31);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_pwm", pwm_out, 0);
        check_eq("async_rst_ready", wr_if.wr_ready, 1);
        check_eq("async_rst_fs", frame_start, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < N_CH; c++) exp_w[c] = 150;
        measure_frame();
        check_widths("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
